mda_motor_ramp: RTL and testbench
=================================

// Module: mda_motor_ramp
// PURPOSE
//  Slew-rate limiter and command sequencer upstream of mda_motor_control, one per thruster.
//  Takes a signed speed command from the host register block and produces on/period/duty_cycle
//  for mda_motor_control in locked-anti-phase form: duty = period/2 means stop.
//  Prevents step reversals that current-spike the H-bridge.
// PARAMETERS
//  TICK_DIV    1000     clk cycles per ramp tick (one slew step per tick); >=1
//  WDT_TICKS   500      ramp ticks without cmd_valid before watchdog stop (MDA_MOTOR_RAMP_WATCHDOG_EN only)
// PORTS
//  clk         in   1   system clock
//  reset       in   1   synchronous, active-high
//  cmd_valid   in   1   one-cycle strobe: cmd_speed/cmd_enable are new
//  cmd_enable  in   1   1 = run, 0 = controlled stop then off
//  cmd_speed   in   16  signed target; +ve/-ve = direction, magnitude in PWM counts
//  cfg_period  in   16  PWM period in cycles; sampled only in OFF
//  cfg_step    in   16  max |speed| change per tick; 0 = no limit (jump in one tick)
//  on          out  1   to mda_motor_control.on
//  period      out  16  to mda_motor_control.period
//  duty_cycle  out  16  to mda_motor_control.duty_cycle
//  cur_speed   out  16  signed present ramped speed (status)
//  busy        out  1   1 while cur_speed != target
//  wdt_fault   out  1   sticky watchdog flag (tied 0 when macro absent)
// BEHAVIOUR
//  Reset: on=0, period=0, duty_cycle=0, cur_speed=0, target=0, busy=0, wdt_fault=0, state=OFF, tick ctr=0.
//  half = period>>1 (15 bits). target = clamp(cmd_speed, -half, +half); signed compare done in 17 bits.
//  Tick: free-running counter 0..TICK_DIV-1; tick=1 for one cycle at wrap; reset clears it.
//  Per tick in RAMP/STOP: d = target - cur (17b). If cfg_step==0 or |d|<=cfg_step, cur<=target;
//  else cur <= cur + sign(d)*cfg_step. Reversal passes through 0 naturally, no special case.
//  Outputs are registered, updated the cycle after the state/cur change. Output latency = 1 clk.
//  duty_cycle = half + cur_speed in 17b, always <= period. busy = (cur_speed != target).
//  FSM:
//   OFF:  on=0, cur=0, duty=half. period<=cfg_period every cycle.
//         cmd_valid & cmd_enable -> latch target, go RAMP.
//   RAMP: on=1. Slew on tick. cur==target -> HOLD.
//   HOLD: on=1. cmd_valid & cmd_enable & new target!=cur -> RAMP.
//   STOP: on=1, target=0. Slew on tick. cur==0 -> OFF (on=0 the following cycle).
//   RAMP/HOLD: cmd_valid & !cmd_enable -> STOP.
//  Simultaneous: cmd_valid on a tick cycle -> tick uses the OLD target; new target applies from
//  the next tick. cmd_valid & cmd_enable in STOP -> latch target, go RAMP (resume without reaching OFF).
//  Period: cfg_period changes outside OFF are ignored. period==0 or 1 -> half=0, all targets clamp to 0.
//  Reset mid-ramp: on drops to 0 next cycle; no controlled stop (H-bridge safe state is off).
// CONFIGURATION
//  `MDA_MOTOR_RAMP_WATCHDOG_EN defined:
//   - Counter of ticks since last cmd_valid, cleared by any cmd_valid and in OFF.
//   - Reaching WDT_TICKS in RAMP/HOLD -> wdt_fault<=1, go STOP.
//   - wdt_fault clears on the next cmd_valid with cmd_enable=1.
//  Undefined: no counter, no watchdog logic; wdt_fault tied 0. Host loss holds last speed.
// STRUCTURE
//  Shared package/defines file mda_motor_ramp_defines.v:
//   - state encodings MDA_RAMP_OFF/RAMP/HOLD/STOP
//   - SPEED_W=16, PERIOD_W=16
//  Sub-module mda_motor_ramp_tick (prescaler: TICK_DIV counter -> tick pulse), instantiated once.
//  FSM, clamp, slew and output registers stay in the top module.
// TESTING
//  1. TICK_DIV=4, period=1000, step=10, cmd +200 enable -> cur steps 10/tick; HOLD after 20 ticks;
//     duty=700, busy=0.
//  2. From HOLD +200, cmd -200 -> cur falls through 0 (duty=500) to -200 (duty=300) in 40 ticks;
//     on stays 1 throughout.
//  3. cmd +900 at period=1000 -> target clamps to +500, duty=1000. Then cfg_period=2000 while HOLD
//     -> period stays 1000.
//  4. step=0, cmd -300 -> cur=-300 on first tick. cmd_enable=0 -> STOP, cur=0, then on=0 one cycle
//     after cur==0.
//  5. cmd_valid coincident with tick -> that tick slews toward old target; new target used from the
//     next tick. Reset mid-RAMP -> on=0, duty=0, cur=0 next cycle.
//  6. WATCHDOG_EN, WDT_TICKS=5, HOLD +100 with no cmd_valid -> wdt_fault=1 after 5 ticks; ramps to 0,
//     OFF. Next enabled cmd_valid clears wdt_fault.

Source files
------------

// File: rtl/mda_motor_ramp_pkg.sv
// Shared types, widths and arithmetic helpers for the motor ramp block.
package mda_motor_ramp_pkg;

  localparam int SPEED_W  = 16;
  localparam int PERIOD_W = 16;

  typedef enum logic [1:0] {
    MDA_RAMP_OFF  = 2'd0,
    MDA_RAMP_RAMP = 2'd1,
    MDA_RAMP_HOLD = 2'd2,
    MDA_RAMP_STOP = 2'd3
  } ramp_state_e;

  // Clamp a signed command into [-period/2, +period/2]; compares are done in 17 bits
  // so that a full-range command never wraps against the half-period bound.
  function automatic logic signed [SPEED_W-1:0] clamp_speed(
    input logic signed [SPEED_W-1:0] cmd,
    input logic [PERIOD_W-1:0]       per
  );
    logic signed [SPEED_W:0] half_s;
    logic signed [SPEED_W:0] neg_half_s;
    logic signed [SPEED_W:0] cmd_s;
    logic signed [SPEED_W:0] res_s;
    half_s     = $signed({2'b00, per[PERIOD_W-1:1]});
    neg_half_s = -half_s;
    cmd_s      = {cmd[SPEED_W-1], cmd};
    if (cmd_s > half_s) begin
      res_s = half_s;
    end else if (cmd_s < neg_half_s) begin
      res_s = neg_half_s;
    end else begin
      res_s = cmd_s;
    end
    return res_s[SPEED_W-1:0];
  endfunction

  // One slew step of cur toward tgt, limited to step counts (0 means jump straight there).
  // When the limit applies the result lies strictly between cur and tgt, so the 16-bit
  // modular add/subtract below cannot overflow.
  function automatic logic signed [SPEED_W-1:0] slew_step(
    input logic signed [SPEED_W-1:0] cur,
    input logic signed [SPEED_W-1:0] tgt,
    input logic [SPEED_W-1:0]        step
  );
    logic [SPEED_W:0]   diff_u;
    logic [SPEED_W:0]   mag;
    logic [SPEED_W-1:0] res;
    diff_u = {tgt[SPEED_W-1], tgt} - {cur[SPEED_W-1], cur};
    mag    = diff_u[SPEED_W] ? ((SPEED_W+1)'(0) - diff_u) : diff_u;
    if ((step == '0) || (mag <= {1'b0, step})) begin
      res = tgt;
    end else if (diff_u[SPEED_W]) begin
      res = cur - step;
    end else begin
      res = cur + step;
    end
    return $signed(res);
  endfunction

endpackage

// File: rtl/mda_motor_ramp_tick.sv
// Ramp-tick prescaler: free-running 0..TICK_DIV-1 counter, one-cycle tick at wrap.
module mda_motor_ramp_tick #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Wrap detection and next count.
  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mda_motor_ramp.sv
// Slew-rate limiter and command sequencer feeding mda_motor_control (locked anti-phase:
// duty = period/2 is stop). Optional host-loss watchdog: MDA_MOTOR_RAMP_WATCHDOG_EN.
module mda_motor_ramp
  import mda_motor_ramp_pkg::*;
#(
  parameter int TICK_DIV  = 1000,
  parameter int WDT_TICKS = 500
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  input  logic                cmd_enable,
  input  logic [SPEED_W-1:0]  cmd_speed,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [SPEED_W-1:0]  cfg_step,
  output logic                on,
  output logic [PERIOD_W-1:0] period,
  output logic [PERIOD_W-1:0] duty_cycle,
  output logic [SPEED_W-1:0]  cur_speed,
  output logic                busy,
  output logic                wdt_fault
);

  ramp_state_e               state_q, state_d;
  logic signed [SPEED_W-1:0] cur_q, cur_d;
  logic signed [SPEED_W-1:0] tgt_q, tgt_d;
  logic [PERIOD_W-1:0]       per_q, per_d;
  logic signed [SPEED_W-1:0] cmd_tgt;
  logic signed [SPEED_W-1:0] slewed;
  logic                      tick;
  logic                      wdt_expire;

  logic                      on_q, on_d;
  logic                      busy_q, busy_d;
  logic [PERIOD_W-1:0]       period_q, period_d;
  logic [PERIOD_W-1:0]       duty_q, duty_d;
  logic [SPEED_W-1:0]        spd_q, spd_d;

  mda_motor_ramp_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Next-state, target and ramped-speed logic. A command arriving on a tick cycle only
  // changes the target register, so that tick still slews toward the old target.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    per_d   = per_q;
    // In OFF the period is being resampled this very cycle, so clamp against the new one.
    cmd_tgt = clamp_speed($signed(cmd_speed), (state_q == MDA_RAMP_OFF) ? cfg_period : per_q);
    slewed  = slew_step(cur_q, tgt_q, cfg_step);
    case (state_q)
      MDA_RAMP_OFF: begin
        per_d = cfg_period;
        cur_d = '0;
        if (cmd_valid && cmd_enable) begin
          tgt_d   = cmd_tgt;
          state_d = MDA_RAMP_RAMP;
        end
      end
      MDA_RAMP_RAMP: begin
        if (tick) cur_d = slewed;
        if (cmd_valid && cmd_enable) begin
          tgt_d = cmd_tgt;
        end else if (cmd_valid || wdt_expire) begin
          tgt_d   = '0;
          state_d = MDA_RAMP_STOP;
        end else if (cur_q == tgt_q) begin
          state_d = MDA_RAMP_HOLD;
        end
      end
      MDA_RAMP_HOLD: begin
        if (cmd_valid && cmd_enable) begin
          tgt_d = cmd_tgt;
          if (cmd_tgt != cur_q) state_d = MDA_RAMP_RAMP;
        end else if (cmd_valid || wdt_expire) begin
          tgt_d   = '0;
          state_d = MDA_RAMP_STOP;
        end
      end
      MDA_RAMP_STOP: begin
        if (tick) cur_d = slewed;
        if (cmd_valid && cmd_enable) begin
          tgt_d   = cmd_tgt;
          state_d = MDA_RAMP_RAMP;
        end else if (cur_q == '0) begin
          state_d = MDA_RAMP_OFF;
        end
      end
      default: begin
        state_d = MDA_RAMP_OFF;
        cur_d   = '0;
        tgt_d   = '0;
      end
    endcase
  end

  // Output values, registered one cycle behind the state/speed registers.
  always_comb begin
    on_d     = (state_q != MDA_RAMP_OFF);
    busy_d   = (cur_q != tgt_q);
    period_d = per_q;
    duty_d   = {1'b0, per_q[PERIOD_W-1:1]} + cur_q;
    spd_d    = cur_q;
  end

  // State, speed and output registers; reset drops straight to off (no controlled stop).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MDA_RAMP_OFF;
      cur_q    <= '0;
      tgt_q    <= '0;
      per_q    <= '0;
      on_q     <= 1'b0;
      busy_q   <= 1'b0;
      period_q <= '0;
      duty_q   <= '0;
      spd_q    <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      tgt_q    <= tgt_d;
      per_q    <= per_d;
      on_q     <= on_d;
      busy_q   <= busy_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      spd_q    <= spd_d;
    end
  end

  assign on         = on_q;
  assign busy       = busy_q;
  assign period     = period_q;
  assign duty_cycle = duty_q;
  assign cur_speed  = spd_q;

`ifdef MDA_MOTOR_RAMP_WATCHDOG_EN
  localparam int WW = $clog2(WDT_TICKS + 1);
  localparam logic [WW-1:0] WDT_LIM = WW'(WDT_TICKS);

  logic [WW-1:0] wdt_cnt_q, wdt_cnt_d;
  logic          wdt_fault_q, wdt_fault_d;

  // Saturating count of ticks since the last command; a fault latches until an enabled command.
  always_comb begin
    wdt_cnt_d   = wdt_cnt_q;
    wdt_fault_d = wdt_fault_q;
    if (cmd_valid || (state_q == MDA_RAMP_OFF)) begin
      wdt_cnt_d = '0;
    end else if (tick && (wdt_cnt_q != WDT_LIM)) begin
      wdt_cnt_d = wdt_cnt_q + 1'b1;
    end
    if (cmd_valid && cmd_enable) begin
      wdt_fault_d = 1'b0;
    end else if (wdt_expire) begin
      wdt_fault_d = 1'b1;
    end
  end

  assign wdt_expire = !cmd_valid && (wdt_cnt_q == WDT_LIM) &&
                      ((state_q == MDA_RAMP_RAMP) || (state_q == MDA_RAMP_HOLD));

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdt_cnt_q   <= '0;
      wdt_fault_q <= 1'b0;
    end else begin
      wdt_cnt_q   <= wdt_cnt_d;
      wdt_fault_q <= wdt_fault_d;
    end
  end

  assign wdt_fault = wdt_fault_q;
`else
  // Without the watchdog a lost host simply leaves the motor at its last speed.
  logic [31:0] unused_wdt_ticks;
  assign unused_wdt_ticks = WDT_TICKS;
  assign wdt_expire       = 1'b0;
  assign wdt_fault        = 1'b0;
`endif

endmodule

// File: tb/tb_mda_motor_ramp.sv
// Directed bench for mda_motor_ramp (TICK_DIV=4, WDT_TICKS=5).
// Build with MDA_MOTOR_RAMP_WATCHDOG_EN defined to exercise the watchdog sequence instead.
module tb_mda_motor_ramp;

  localparam int TICK_DIV  = 4;
  localparam int WDT_TICKS = 5;
  localparam int TICK_WAIT = 4 * TICK_DIV + 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_enable;
  logic [15:0] cmd_speed;
  logic [15:0] cfg_period;
  logic [15:0] cfg_step;
  logic        on;
  logic [15:0] period;
  logic [15:0] duty_cycle;
  logic [15:0] cur_speed;
  logic        busy;
  logic        wdt_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mda_motor_ramp #(.TICK_DIV(TICK_DIV), .WDT_TICKS(WDT_TICKS)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_enable (cmd_enable),
    .cmd_speed  (cmd_speed),
    .cfg_period (cfg_period),
    .cfg_step   (cfg_step),
    .on         (on),
    .period     (period),
    .duty_cycle (duty_cycle),
    .cur_speed  (cur_speed),
    .busy       (busy),
    .wdt_fault  (wdt_fault)
  );

  task automatic chk16(input string tag, input logic [15:0] obs, input int exp_v);
    logic [15:0] e;
    e = exp_v[15:0];
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(e));
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Stop at the negedge just before a tick edge (bounded).
  task automatic align_tick();
    int guard;
    guard = 0;
    while (dut.tick !== 1'b1 && guard < TICK_WAIT) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= TICK_WAIT) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout observed=%0d cycles required<%0d", guard, TICK_WAIT);
    end
  endtask

  // Let n ticks take effect, then one more cycle so the registered outputs show them.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      align_tick();
      step(1);
    end
    step(1);
  endtask

  task automatic pulse(input logic en, input int spd);
    cmd_valid  = 1'b1;
    cmd_enable = en;
    cmd_speed  = spd[15:0];
    $display("cmd enable=%0d speed=%0d", en, spd);
    step(1);
    cmd_valid  = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_enable = 1'b0;
    cmd_speed  = '0;
    cfg_period = 16'd1000;
    cfg_step   = 16'd10;
    step(3);
    chk1 ("rst_on",     on,         1'b0);
    chk16("rst_period", period,     0);
    chk16("rst_duty",   duty_cycle, 0);
    chk16("rst_cur",    cur_speed,  0);
    chk1 ("rst_busy",   busy,       1'b0);
    chk1 ("rst_wdt",    wdt_fault,  1'b0);
    reset = 1'b0;
    step(3);
    chk16("off_period", period,     1000);
    chk16("off_duty",   duty_cycle, 500);
    chk1 ("off_on",     on,         1'b0);

`ifndef MDA_MOTOR_RAMP_WATCHDOG_EN
    // 1: ramp up in 10-count steps to +200
    pulse(1'b1, 200);
    ticks(1);
    chk16("t1_cur1",  cur_speed,  10);
    chk16("t1_duty1", duty_cycle, 510);
    chk1 ("t1_on",    on,         1'b1);
    chk1 ("t1_busy",  busy,       1'b1);
    ticks(19);
    chk16("t1_cur",   cur_speed,  200);
    chk16("t1_duty",  duty_cycle, 700);
    chk1 ("t1_idle",  busy,       1'b0);
    chk1 ("t1_wdt",   wdt_fault,  1'b0);

    // 2: reversal through zero
    pulse(1'b1, -200);
    ticks(20);
    chk16("t2_cur0",  cur_speed,  0);
    chk16("t2_duty0", duty_cycle, 500);
    chk1 ("t2_on0",   on,         1'b1);
    ticks(20);
    chk16("t2_cur",   cur_speed,  -200);
    chk16("t2_duty",  duty_cycle, 300);
    chk1 ("t2_on",    on,         1'b1);
    chk1 ("t2_idle",  busy,       1'b0);

    // 3: clamp to +period/2, period frozen outside OFF
    pulse(1'b1, 900);
    ticks(1);
    chk16("t3_cur1",  cur_speed,  -190);
    chk1 ("t3_busy",  busy,       1'b1);
    ticks(69);
    chk16("t3_cur",   cur_speed,  500);
    chk16("t3_duty",  duty_cycle, 1000);
    chk1 ("t3_idle",  busy,       1'b0);
    cfg_period = 16'd2000;
    step(4);
    chk16("t3_period", period,     1000);
    chk16("t3_duty2",  duty_cycle, 1000);
    cfg_period = 16'd1000;

    // 4: unlimited step, then controlled stop to OFF
    cfg_step = 16'd0;
    pulse(1'b1, -300);
    ticks(1);
    chk16("t4_cur",   cur_speed,  -300);
    chk16("t4_duty",  duty_cycle, 200);
    chk1 ("t4_idle",  busy,       1'b0);
    pulse(1'b0, 0);
    ticks(1);
    chk16("t4_stop_cur", cur_speed, 0);
    chk1 ("t4_stop_on",  on,        1'b1);
    step(1);
    chk1 ("t4_off_on",   on,         1'b0);
    chk16("t4_off_duty", duty_cycle, 500);

    // 5: command coincident with a tick uses the old target on that tick
    cfg_step = 16'd10;
    pulse(1'b1, 100);
    ticks(2);
    chk16("t5_cur20", cur_speed, 20);
    align_tick();
    pulse(1'b1, -100);
    step(1);
    chk16("t5_old_tgt", cur_speed, 30);
    ticks(1);
    chk16("t5_new_tgt", cur_speed, 20);
    chk1 ("t5_busy",    busy,      1'b1);
    reset = 1'b1;
    step(1);
    chk1 ("t5_rst_on",   on,         1'b0);
    chk16("t5_rst_duty", duty_cycle, 0);
    chk16("t5_rst_cur",  cur_speed,  0);
    reset = 1'b0;

    // Degenerate period: half is 0 so every target clamps to 0
    cfg_period = 16'd1;
    step(2);
    pulse(1'b1, 50);
    ticks(1);
    chk16("p1_cur",    cur_speed,  0);
    chk16("p1_duty",   duty_cycle, 0);
    chk16("p1_period", period,     1);
    chk1 ("p1_on",     on,         1'b1);
    chk1 ("p1_idle",   busy,       1'b0);
`else
    // 6: watchdog stop after WDT_TICKS ticks without a command
    cfg_step = 16'd0;
    pulse(1'b1, 100);
    ticks(4);
    chk16("t6_cur",      cur_speed, 100);
    chk1 ("t6_wdt_pre",  wdt_fault, 1'b0);
    ticks(1);
    chk1 ("t6_wdt",      wdt_fault, 1'b1);
    ticks(1);
    chk16("t6_stop_cur", cur_speed, 0);
    step(1);
    chk1 ("t6_off_on",   on,        1'b0);
    chk1 ("t6_sticky",   wdt_fault, 1'b1);
    pulse(1'b1, 100);
    chk1 ("t6_clear",    wdt_fault, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
